// File: rtl/dmx_usb_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : dmx_usb_packetizer
// Description : Buffers DMX slot bytes in a small FIFO and wraps each DMX
//               packet into a byte-stuffed frame for a USB CDC byte sink:
//                 0x7E SOF, escaped payload (start code + slots),
//                 escaped 16-bit slot count, escaped 8-bit checksum.
//               Absorbs sink back-pressure and reports FIFO overflow.
// Ports       : i_Clock      - system clock
//               i_Reset      - synchronous active-high reset
//               i_SlotValid  - one-cycle strobe, i_SlotData holds a slot byte
//               i_SlotData   - received slot byte
//               i_Break      - DMX break level, rising edge starts a packet
//               i_usbReady   - sink accepts o_data this cycle
//               o_dataReady  - o_data is valid
//               o_data       - framed output byte
//               o_Overflow   - sticky, an entry was dropped since reset
//               o_DropCount  - dropped entries, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module dmx_usb_packetizer #(
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_SLOTS  = 513
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_SlotValid,
    input  logic [7:0] i_SlotData,
    input  logic       i_Break,
    input  logic       i_usbReady,
    output logic       o_dataReady,
    output logic [7:0] o_data,
    output logic       o_Overflow,
    output logic [7:0] o_DropCount
);

    localparam int         c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [8:0] c_MARKER = 9'h100;
    localparam logic [15:0] c_MAX   = 16'(MAX_SLOTS);
    localparam logic [7:0] c_SOF    = 8'h7E;
    localparam logic [7:0] c_ESC    = 8'h7D;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SOF    = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_ESC    = 3'd3;
    localparam logic [2:0] c_ST_CNT_HI = 3'd4;
    localparam logic [2:0] c_ST_CNT_LO = 3'd5;
    localparam logic [2:0] c_ST_CSUM   = 3'd6;

    // ------------------------------------------------------------------------
    // Input side: break edge detection, pending marker, write selection
    // ------------------------------------------------------------------------
    logic                r_break_d;
    logic                r_pend;
    logic                w_edge;

    logic [8:0]          r_mem [0:FIFO_DEPTH-1];
    logic [c_ADDR_W:0]   r_wr_ptr;
    logic [c_ADDR_W:0]   r_rd_ptr;
    logic [c_ADDR_W:0]   w_fill;
    logic                w_empty;
    logic [8:0]          w_head;
    logic [c_ADDR_W-1:0] w_wr_addr1;
    logic [c_ADDR_W+1:0] w_room;

    logic                w_a_vld, w_b_vld;
    logic [8:0]          w_a_dat, w_b_dat;
    logic                w_a_acc, w_b_acc;
    logic [1:0]          w_n_wr;
    logic [1:0]          w_drops;
    logic [8:0]          w_drop_sum;

    logic                r_ovf;
    logic [7:0]          r_drop;

    logic                w_pop;

    assign w_edge     = i_Break & ~r_break_d;
    assign w_fill     = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_head     = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign w_wr_addr1 = r_wr_ptr[c_ADDR_W-1:0] + c_ADDR_W'(1);

    // A pop in the same cycle frees one entry for the incoming write.
    assign w_room = (c_ADDR_W+2)'(FIFO_DEPTH) - {1'b0, w_fill}
                  + {{(c_ADDR_W+1){1'b0}}, w_pop};

    // Up to two entries per cycle: a marker held over from the previous
    // cycle always goes ahead of a slot arriving now. When an edge and a
    // slot coincide, the slot goes first and the marker waits one cycle.
    always_comb begin
        w_a_vld = 1'b0;
        w_a_dat = 9'h000;
        w_b_vld = 1'b0;
        w_b_dat = 9'h000;
        if (r_pend) begin
            w_a_vld = 1'b1;
            w_a_dat = c_MARKER;
            w_b_vld = i_SlotValid;
            w_b_dat = {1'b0, i_SlotData};
        end else if (i_SlotValid) begin
            w_a_vld = 1'b1;
            w_a_dat = {1'b0, i_SlotData};
        end else if (w_edge) begin
            w_a_vld = 1'b1;
            w_a_dat = c_MARKER;
        end
    end

    // The second entry only fits if the first did and one more slot is free.
    assign w_a_acc    = w_a_vld & (w_room != '0);
    assign w_b_acc    = w_b_vld & (w_room >= (c_ADDR_W+2)'(2));
    assign w_n_wr     = {1'b0, w_a_acc} + {1'b0, w_b_acc};
    assign w_drops    = {1'b0, w_a_vld & ~w_a_acc} + {1'b0, w_b_vld & ~w_b_acc};
    assign w_drop_sum = {1'b0, r_drop} + {7'b0, w_drops};

    always_ff @(posedge i_Clock) begin
        if (w_a_acc) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= w_a_dat;
        end
        if (w_b_acc) begin
            r_mem[w_wr_addr1] <= w_b_dat;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_break_d <= 1'b0;
            r_pend    <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ovf     <= 1'b0;
            r_drop    <= 8'h00;
        end else begin
            r_break_d <= i_Break;
            r_pend    <= w_edge & i_SlotValid & ~r_pend;
            r_wr_ptr  <= r_wr_ptr + {{(c_ADDR_W-1){1'b0}}, w_n_wr};
            r_rd_ptr  <= r_rd_ptr + {{c_ADDR_W{1'b0}}, w_pop};
            if (w_drops != 2'd0) begin
                r_ovf  <= 1'b1;
                r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output side: framing FSM
    // r_state names the next byte to produce once the output register is
    // free, so a new byte can follow an accepted one on the very next clock.
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [2:0]  r_resume;     // state to continue with after ESC
    logic [2:0]  r_ret;        // state after the trailer: IDLE or SOF
    logic [7:0]  r_esc_byte;
    logic [15:0] r_count;
    logic [7:0]  r_csum;
    logic        r_valid;
    logic [7:0]  r_data;

    logic        w_free;
    logic        w_emit;
    logic [7:0]  w_raw;
    logic        w_can_esc;
    logic        w_need_esc;
    logic [2:0]  w_after;
    logic        w_clr;
    logic        w_add;
    logic        w_set_ret;
    logic [2:0]  w_ret_val;
    logic [15:0] w_cnt_inc;

    assign w_free    = ~r_valid | i_usbReady;
    assign w_cnt_inc = r_count + 16'd1;

    always_comb begin
        w_pop     = 1'b0;
        w_emit    = 1'b0;
        w_raw     = 8'h00;
        w_can_esc = 1'b0;
        w_after   = r_state;
        w_clr     = 1'b0;
        w_add     = 1'b0;
        w_set_ret = 1'b0;
        w_ret_val = c_ST_IDLE;
        if (w_free) begin
            case (r_state)
                c_ST_IDLE: begin
                    // Data outside a frame is discarded until a marker.
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head[8]) begin
                            w_emit  = 1'b1;
                            w_raw   = c_SOF;
                            w_clr   = 1'b1;
                            w_after = c_ST_DATA;
                        end
                    end
                end
                c_ST_SOF: begin
                    w_emit  = 1'b1;
                    w_raw   = c_SOF;
                    w_clr   = 1'b1;
                    w_after = c_ST_DATA;
                end
                c_ST_DATA: begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_emit    = 1'b1;
                        w_can_esc = 1'b1;
                        if (w_head[8]) begin
                            // Marker closes the frame; the count high byte
                            // goes out right away.
                            w_raw     = r_count[15:8];
                            w_after   = c_ST_CNT_LO;
                            w_set_ret = 1'b1;
                            w_ret_val = c_ST_SOF;
                        end else begin
                            w_add = 1'b1;
                            w_raw = w_head[7:0];
                            if (w_cnt_inc == c_MAX) begin
                                w_after   = c_ST_CNT_HI;
                                w_set_ret = 1'b1;
                                w_ret_val = c_ST_IDLE;
                            end else begin
                                w_after = c_ST_DATA;
                            end
                        end
                    end
                end
                c_ST_ESC: begin
                    w_emit  = 1'b1;
                    w_raw   = r_esc_byte;
                    w_after = r_resume;
                end
                c_ST_CNT_HI: begin
                    w_emit    = 1'b1;
                    w_can_esc = 1'b1;
                    w_raw     = r_count[15:8];
                    w_after   = c_ST_CNT_LO;
                end
                c_ST_CNT_LO: begin
                    w_emit    = 1'b1;
                    w_can_esc = 1'b1;
                    w_raw     = r_count[7:0];
                    w_after   = c_ST_CSUM;
                end
                c_ST_CSUM: begin
                    w_emit    = 1'b1;
                    w_can_esc = 1'b1;
                    w_raw     = r_csum;
                    w_after   = r_ret;
                end
                default: begin
                    w_after = c_ST_IDLE;
                end
            endcase
        end
    end

    assign w_need_esc = w_can_esc & ((w_raw == c_SOF) | (w_raw == c_ESC));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state    <= c_ST_IDLE;
            r_resume   <= c_ST_IDLE;
            r_ret      <= c_ST_IDLE;
            r_esc_byte <= 8'h00;
            r_count    <= 16'h0000;
            r_csum     <= 8'h00;
            r_valid    <= 1'b0;
            r_data     <= 8'h00;
        end else begin
            if (w_clr) begin
                r_count <= 16'h0000;
                r_csum  <= 8'h00;
            end else if (w_add) begin
                r_count <= w_cnt_inc;
                r_csum  <= r_csum + w_head[7:0];
            end
            if (w_set_ret) begin
                r_ret <= w_ret_val;
            end
            // Output register only changes when empty or being accepted.
            if (w_free) begin
                r_valid <= w_emit;
                if (w_emit && w_need_esc) begin
                    r_data     <= c_ESC;
                    r_esc_byte <= w_raw ^ 8'h20;
                    r_resume   <= w_after;
                    r_state    <= c_ST_ESC;
                end else begin
                    if (w_emit) begin
                        r_data <= w_raw;
                    end
                    r_state <= w_after;
                end
            end
        end
    end

    assign o_dataReady = r_valid;
    assign o_data      = r_data;
    assign o_Overflow  = r_ovf;
    assign o_DropCount = r_drop;

endmodule
`default_nettype wire
